// File: rtl/cr_axi4s_pkt_arb_pkg.sv
// Shared AXI4-Stream datapath types and the packet arbiter state encoding.
package cr_axi4s_pkt_arb_pkg;

  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tid;
    logic [3:0]  tuser;
    logic [3:0]  tstrb;
    logic [31:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  typedef enum logic {ARB_IDLE, ARB_XFER} axi4s_arb_st_e;

endpackage

// File: rtl/cr_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module cr_rr_pick #(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [SRC_W-1:0] sel;

  // Scan offsets from farthest to nearest so the nearest request to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sel     = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sel = SRC_W'((int'(ptr) + k) % N_SRC);
      if (req[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end
  end

endmodule

// File: rtl/cr_axi4s_pkt_arb.sv
// Packet-granular round-robin arbiter feeding one registered AXI4-S output stage.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ARB_IDLE | no grant held; pick next eligible source from rr_ptr
//  ARB_XFER | grant held on arb_src; pop beats until the tlast beat leaves
module cr_axi4s_pkt_arb
  import cr_axi4s_pkt_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic          [N_SRC-1:0]       cfg_src_en,
  input  axi4s_dp_bus_t [N_SRC-1:0]       axi4s_in,
  input  logic          [N_SRC-1:0]       axi4s_in_empty,
  output logic          [N_SRC-1:0]       axi4s_mstr_rd,
  input  axi4s_dp_rdy_t                   axi4s_ob_in,
  output axi4s_dp_bus_t                   axi4s_ob_out,
  output logic                            arb_busy,
  output logic          [SRC_W-1:0]       arb_src
);

  axi4s_arb_st_e    state, state_nxt;
  logic [SRC_W-1:0] rr_ptr;
  logic [N_SRC-1:0] req;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_vld;
  logic             pop;
  axi4s_dp_bus_t    head;

  assign req      = ~axi4s_in_empty & cfg_src_en;
  assign head     = axi4s_in[arb_src];
  assign arb_busy = (state == ARB_XFER);

  cr_rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Pop the granted FIFO whenever it has data and the output slot is free or draining.
  always_comb begin
    pop = (state == ARB_XFER) & ~axi4s_in_empty[arb_src]
          & (~axi4s_ob_out.tvalid | axi4s_ob_in.tready);
    axi4s_mstr_rd          = '0;
    axi4s_mstr_rd[arb_src] = pop;
  end

  // Next-state: grant when anything is eligible, release after the tlast beat is popped.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_vld) state_nxt = ARB_XFER;
      ARB_XFER: if (pop && head.tlast) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Latch the grant in IDLE; advance the round-robin pointer past the source on packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_src <= '0;
      rr_ptr  <= '0;
    end else begin
      if (state == ARB_IDLE && pick_vld) arb_src <= pick_idx;
      if (pop && head.tlast)
        rr_ptr <= (arb_src == SRC_W'(N_SRC - 1)) ? '0 : arb_src + SRC_W'(1);
    end
  end

  // One-entry output stage: load on pop, clear on accept, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi4s_ob_out <= '0;
    end else if (pop) begin
      axi4s_ob_out        <= head;
      axi4s_ob_out.tvalid <= 1'b1;
    end else if (axi4s_ob_out.tvalid && axi4s_ob_in.tready) begin
      axi4s_ob_out.tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cr_axi4s_pkt_arb.sv
// Directed bench for cr_axi4s_pkt_arb with show-ahead FIFO models and an output log.
module tb_cr_axi4s_pkt_arb;
  import cr_axi4s_pkt_arb_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic          [3:0]       cfg_src_en;
  axi4s_dp_bus_t [3:0]       fifo_head;
  logic          [3:0]       fifo_empty;
  logic          [3:0]       rd;
  axi4s_dp_rdy_t             ob_rdy;
  axi4s_dp_bus_t             ob;
  logic                      busy;
  logic          [1:0]       src;

  axi4s_dp_bus_t q [4][$];
  axi4s_dp_bus_t outq [$];
  int            outcyc [$];
  logic [3:0]    rdh [64];
  logic          vh [64];
  logic [3:0]    rd_s;
  int            hn;
  int            cyc;
  int            errors;
  int            checks;
  logic [5:0]    r0, v0;
  logic [2:0]    rhi;

  cr_axi4s_pkt_arb #(.N_SRC(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_src_en     (cfg_src_en),
    .axi4s_in       (fifo_head),
    .axi4s_in_empty (fifo_empty),
    .axi4s_mstr_rd  (rd),
    .axi4s_ob_in    (ob_rdy),
    .axi4s_ob_out   (ob),
    .arb_busy       (busy),
    .arb_src        (src)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int s, input int p, input int b);
    return {8'(s), 8'(p), 8'h00, 8'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_head[i]  = (q[i].size() == 0) ? '0 : q[i][0];
    end
  endtask

  task automatic push_pkt(input int s, input int p, input int first, input int last, input int total);
    axi4s_dp_bus_t bt;
    for (int b = first; b <= last; b++) begin
      bt        = '0;
      bt.tlast  = (b == total);
      bt.tid    = 4'(p);
      bt.tuser  = 4'(s);
      bt.tstrb  = 4'hF;
      bt.tdata  = mk(s, p, b);
      q[s].push_back(bt);
    end
    refresh();
  endtask

  // Sample at negedge, then pop the model FIFOs just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hn < 64) begin
      rdh[hn] = rd;
      vh[hn]  = ob.tvalid;
      hn++;
    end
    if (ob.tvalid && ob_rdy.tready) begin
      outq.push_back(ob);
      outcyc.push_back(cyc);
    end
    rd_s = rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (rd_s[i] && q[i].size() > 0) void'(q[i].pop_front());
    refresh();
  endtask

  task automatic clr_log();
    hn = 0;
    outq.delete();
    outcyc.delete();
  endtask

  task automatic clr_fifos();
    for (int i = 0; i < 4; i++) q[i].delete();
    refresh();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cfg_src_en = 4'hF;
    ob_rdy     = '{tready: 1'b1};
    clr_fifos();
    tick();
    tick();
    rst_n = 1'b1;
    clr_log();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    hn     = 0;
    rd_s   = '0;
    rst_n  = 1'b0;
    cfg_src_en = 4'hF;
    ob_rdy = '{tready: 1'b1};
    refresh();
    tick();
    tick();

    // Reset state
    chk("rst_ob", 64'(ob), 64'h0);
    chk("rst_rd", 64'(rd), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_src", 64'(src), 64'h0);

    // 1: src0 alone, 3-beat packet
    rst_n = 1'b1;
    clr_log();
    push_pkt(0, 1, 1, 3, 3);
    for (int i = 0; i < 6; i++) tick();
    rhi = '0;
    for (int i = 0; i < 6; i++) begin
      r0[i] = rdh[i][0];
      v0[i] = vh[i];
      rhi   = rhi | rdh[i][3:1];
    end
    chk("t1_rd0_pattern", 64'(r0), 64'b001110);
    chk("t1_rd_other", 64'(rhi), 64'h0);
    chk("t1_tvalid_pattern", 64'(v0), 64'b011100);
    chk("t1_nbeats", 64'(outq.size()), 64'd3);
    if (outq.size() == 3) begin
      chk("t1_b1", 64'(outq[0].tdata), 64'(mk(0, 1, 1)));
      chk("t1_b3", 64'(outq[2].tdata), 64'(mk(0, 1, 3)));
      chk("t1_tlast", 64'({outq[0].tlast, outq[1].tlast, outq[2].tlast}), 64'b001);
      chk("t1_tid", 64'(outq[1].tid), 64'd1);
    end
    chk("t1_src", 64'(src), 64'd0);

    // 2: four sources, two single-beat packets each
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++) push_pkt(s, p, 1, 1, 1);
    for (int i = 0; i < 22; i++) tick();
    chk("t2_count", 64'(outq.size()), 64'd8);
    if (outq.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t2_order", 64'(outq[k].tdata), 64'(mk(k % 4, k / 4, 1)));
        if (k > 0) chk("t2_spacing", 64'(outcyc[k] - outcyc[k-1]), 64'd2);
      end
    end

    // 3: src1 4-beat packet, downstream stalls 5 clks on beat 2
    do_reset();
    push_pkt(1, 3, 1, 4, 4);
    for (int i = 0; i < 3; i++) tick();
    ob_rdy = '{tready: 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold", 64'({ob.tvalid, ob.tdata}), 64'({1'b1, mk(1, 3, 2)}));
      chk("t3_no_rd", 64'(rd_s), 64'h0);
    end
    ob_rdy = '{tready: 1'b1};
    for (int i = 0; i < 8; i++) tick();
    chk("t3_count", 64'(outq.size()), 64'd4);
    if (outq.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("t3_beat", 64'(outq[k].tdata), 64'(mk(1, 3, k + 1)));
      chk("t3_tlast", 64'({outq[1].tlast, outq[3].tlast}), 64'b01);
    end

    // 4: src2 runs dry after beat 2 of 5 while src3 waits
    do_reset();
    push_pkt(2, 4, 1, 2, 5);
    push_pkt(3, 5, 1, 1, 1);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_grant", 64'({busy, src, rd_s}), 64'({1'b1, 2'd2, 4'b0000}));
    end
    push_pkt(2, 4, 3, 5, 5);
    for (int i = 0; i < 12; i++) tick();
    chk("t4_count", 64'(outq.size()), 64'd6);
    if (outq.size() == 6) begin
      for (int k = 0; k < 5; k++) chk("t4_src2", 64'(outq[k].tdata), 64'(mk(2, 4, k + 1)));
      chk("t4_src3", 64'(outq[5].tdata), 64'(mk(3, 5, 1)));
    end

    // 5: src2 masked; src0 masked mid-packet
    do_reset();
    push_pkt(0, 6, 1, 3, 3);
    push_pkt(0, 7, 1, 1, 1);
    push_pkt(1, 8, 1, 1, 1);
    push_pkt(1, 9, 1, 1, 1);
    push_pkt(2, 10, 1, 1, 1);
    push_pkt(3, 11, 1, 1, 1);
    push_pkt(3, 12, 1, 1, 1);
    cfg_src_en = 4'b1011;
    tick();
    tick();
    cfg_src_en = 4'b1010;
    for (int i = 0; i < 24; i++) tick();
    chk("t5_count", 64'(outq.size()), 64'd7);
    if (outq.size() == 7) begin
      chk("t5_0", 64'(outq[0].tdata), 64'(mk(0, 6, 1)));
      chk("t5_1", 64'(outq[1].tdata), 64'(mk(0, 6, 2)));
      chk("t5_2", 64'(outq[2].tdata), 64'(mk(0, 6, 3)));
      chk("t5_3", 64'(outq[3].tdata), 64'(mk(1, 8, 1)));
      chk("t5_4", 64'(outq[4].tdata), 64'(mk(3, 11, 1)));
      chk("t5_5", 64'(outq[5].tdata), 64'(mk(1, 9, 1)));
      chk("t5_6", 64'(outq[6].tdata), 64'(mk(3, 12, 1)));
    end
    chk("t5_src2_left", 64'(q[2].size()), 64'd1);
    chk("t5_src0_left", 64'(q[0].size()), 64'd1);
    chk("t5_idle", 64'(busy), 64'd0);

    // 6: reset during beat 2 of a src0 packet, pointer previously at 3
    do_reset();
    push_pkt(2, 13, 1, 1, 1);
    for (int i = 0; i < 4; i++) tick();
    push_pkt(0, 14, 1, 4, 4);
    for (int i = 0; i < 3; i++) tick();
    chk("t6_pre", 64'({ob.tvalid, ob.tdata}), 64'({1'b1, mk(0, 14, 2)}));
    rst_n = 1'b0;
    clr_fifos();
    tick();
    chk("t6_rst_vld", 64'(ob.tvalid), 64'd0);
    chk("t6_rst_rd", 64'(rd_s), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    clr_log();
    push_pkt(3, 15, 1, 1, 1);
    push_pkt(0, 16, 1, 1, 1);
    tick();
    chk("t6_grant", 64'({busy, src}), 64'({1'b1, 2'd0}));
    for (int i = 0; i < 6; i++) tick();
    chk("t6_count", 64'(outq.size()), 64'd2);
    if (outq.size() == 2) begin
      chk("t6_first", 64'(outq[0].tdata), 64'(mk(0, 16, 1)));
      chk("t6_second", 64'(outq[1].tdata), 64'(mk(3, 15, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
